dlx_instr_sequencer: RTL and testbench

//  Multicycle control FSM for the extended DLX core. Sequences fetch/decode/execute/writeback per instruction.

---
 rtl/dlx_instr_sequencer_pkg.sv | 22 ++
 rtl/dlx_instr_sequencer_fetch_watchdog.sv | 28 ++
 rtl/dlx_instr_sequencer.sv | 131 +++++++++++++
 tb/tb_dlx_instr_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_instr_sequencer_pkg.sv
// rtl/dlx_instr_sequencer_pkg.sv - state encodings and defaults shared by the DLX instruction sequencer
package dlx_instr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_t;

  localparam int         INSTR_W_DEF  = 32;
  localparam int         OPC_W_DEF    = 6;
  localparam logic [5:0] HALT_OPC_DEF = 6'h3F;
  localparam int         FETCH_TO_DEF = 15;

  localparam int WDOG_W = 8;
  localparam int PC_W   = 16;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/dlx_instr_sequencer_fetch_watchdog.sv
// rtl/dlx_instr_sequencer_fetch_watchdog.sv - loadable down-counter bounding the time spent waiting in FETCH
module dlx_instr_sequencer_fetch_watchdog
  import dlx_instr_sequencer_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic [WDOG_W-1:0] load_val,
  input  logic              en,
  output logic              expired
);

  logic [WDOG_W-1:0] cnt;

  // Saturates at zero so a stalled FETCH keeps reporting expiry until reloaded.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - WDOG_W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/dlx_instr_sequencer.sv
// rtl/dlx_instr_sequencer.sv - multicycle fetch/decode/execute/writeback control FSM driving the PC counter
module dlx_instr_sequencer
  import dlx_instr_sequencer_pkg::*;
#(
  parameter int               INSTR_W  = INSTR_W_DEF,
  parameter int               OPC_W    = OPC_W_DEF,
  parameter logic [OPC_W-1:0] HALT_OPC = OPC_W'(HALT_OPC_DEF),
  parameter int               FETCH_TO = FETCH_TO_DEF
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               RUN,
  input  logic               STEP,
  output logic               IMEM_REQ,
  input  logic               IMEM_ACK,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  output logic [PC_W-1:0]    IMEM_ADDR,
  output logic [INSTR_W-1:0] IR,
  output logic               EX_START,
  input  logic               EX_DONE,
  output logic               RF_WE,
  output logic               PC_EN,
  output logic               HALTED,
  output logic               FETCH_ERR,
  output logic [2:0]         STATE,
  output logic [CNT_W-1:0]   INSTR_CNT
);

  seq_state_t         state;
  seq_state_t         next_state;
  logic               step_mode;
  logic               step_mode_d;
  logic               imem_req_d;
  logic               ex_start_d;
  logic               wb_d;
  logic               halted_d;
  logic               fetch_err_d;
  logic [INSTR_W-1:0] ir_d;
  logic [CNT_W-1:0]   instr_cnt;
  logic [CNT_W-1:0]   instr_cnt_d;
  logic [PC_W-1:0]    pc;
  logic [OPC_W-1:0]   opcode;
  logic               wdog_load;
  logic               wdog_expired;

  assign opcode    = IR[INSTR_W-1 -: OPC_W];
  assign STATE     = state;
  assign INSTR_CNT = instr_cnt;
  assign IMEM_ADDR = pc;

  // Reloaded on every entry into FETCH, counts only while fetching.
  assign wdog_load = (next_state == ST_FETCH) && (state != ST_FETCH);

  dlx_instr_sequencer_fetch_watchdog u_fetch_watchdog (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (wdog_load),
    .load_val (WDOG_W'(FETCH_TO - 1)),
    .en       (state == ST_FETCH),
    .expired  (wdog_expired)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      step_mode <= 1'b0;
      IMEM_REQ  <= 1'b0;
      EX_START  <= 1'b0;
      RF_WE     <= 1'b0;
      PC_EN     <= 1'b0;
      HALTED    <= 1'b0;
      FETCH_ERR <= 1'b0;
      IR        <= '0;
      instr_cnt <= '0;
    end else begin
      state     <= next_state;
      step_mode <= step_mode_d;
      IMEM_REQ  <= imem_req_d;
      EX_START  <= ex_start_d;
      RF_WE     <= wb_d;
      PC_EN     <= wb_d;
      HALTED    <= halted_d;
      FETCH_ERR <= fetch_err_d;
      IR        <= ir_d;
      instr_cnt <= instr_cnt_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!FETCH_ERR && (RUN || STEP)) next_state = ST_FETCH;
      ST_FETCH: begin
        // A late ACK arriving on the expiry cycle still completes the fetch.
        if (IMEM_ACK)          next_state = ST_DECODE;
        else if (wdog_expired) next_state = ST_IDLE;
      end
      ST_DECODE: next_state = (opcode == HALT_OPC) ? ST_HALT : ST_EXEC;
      ST_EXEC:   if (EX_DONE) next_state = ST_WB;
      ST_WB:     next_state = (RUN && !step_mode) ? ST_FETCH : ST_IDLE;
      ST_HALT:   next_state = ST_HALT;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    step_mode_d = step_mode;
    if ((state == ST_IDLE) && (next_state == ST_FETCH)) begin
      step_mode_d = !RUN;
    end else if (state == ST_WB) begin
      step_mode_d = 1'b0;
    end
    imem_req_d  = (next_state == ST_FETCH);
    ex_start_d  = (state == ST_DECODE) && (next_state == ST_EXEC);
    wb_d        = (next_state == ST_WB);
    halted_d    = HALTED || (next_state == ST_HALT);
    fetch_err_d = FETCH_ERR || ((state == ST_FETCH) && !IMEM_ACK && wdog_expired);
    ir_d        = ((state == ST_FETCH) && IMEM_ACK) ? IMEM_RDATA : IR;
    instr_cnt_d = wb_d ? instr_cnt + CNT_W'(1) : instr_cnt;
  end

  // Program counter advances on the cycle after each write-back strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc <= '0;
    end else if (PC_EN) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: tb/tb_dlx_instr_sequencer.sv
// tb/tb_dlx_instr_sequencer.sv - vector table, corner sequences and randomized model check for dlx_instr_sequencer
module tb_dlx_instr_sequencer;

  localparam int          TO = 15;
  localparam int          N  = 24;
  localparam logic [31:0] W1 = 32'h0412_3456;
  localparam logic [31:0] W2 = 32'h0800_00AA;
  localparam logic [31:0] W3 = 32'h0C00_00BB;
  localparam logic [31:0] W4 = 32'h1400_0005;
  localparam logic [31:0] WH = 32'hFC00_0000;
  localparam logic [31:0] XW = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        RESET, RUN, STEP, IMEM_ACK, EX_DONE;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_REQ, EX_START, RF_WE, PC_EN, HALTED, FETCH_ERR;
  logic [31:0] IR;
  logic [2:0]  STATE;
  logic [15:0] INSTR_CNT, IMEM_ADDR;

  int n_vec = 0;
  int n_err = 0;

  dlx_instr_sequencer #(
    .INSTR_W(32), .OPC_W(6), .HALT_OPC(6'h3F), .FETCH_TO(TO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP),
    .IMEM_REQ(IMEM_REQ), .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .IMEM_ADDR(IMEM_ADDR),
    .IR(IR), .EX_START(EX_START), .EX_DONE(EX_DONE), .RF_WE(RF_WE), .PC_EN(PC_EN),
    .HALTED(HALTED), .FETCH_ERR(FETCH_ERR), .STATE(STATE), .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  // ins = {rst, run, step, ack, done}; outs = {req, ex_start, rf_we, pc_en, fetch_err, halted}
  typedef struct {
    logic [4:0]  ins;
    logic [31:0] rdata;
    logic [2:0]  st;
    logic [5:0]  outs;
    logic [15:0] cnt;
    logic [15:0] addr;
    logic [31:0] ir;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] ins, input logic [31:0] rdata, input logic [2:0] st,
                              input logic [5:0] outs, input logic [15:0] cnt, input logic [15:0] addr,
                              input logic [31:0] ir);
    vec_t v;
    v.ins = ins; v.rdata = rdata; v.st = st; v.outs = outs; v.cnt = cnt; v.addr = addr; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic run, input logic step, input logic ack,
                       input logic done, input logic [31:0] rd);
    RESET = rst; RUN = run; STEP = step; IMEM_ACK = ack; EX_DONE = done; IMEM_RDATA = rd;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, XW);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, XW);
  endtask

  logic [31:0] words [N];
  int          da [N];
  int          de [N];
  int          exp_wb [$];

  initial begin
    int   n_req, pce_cnt, t, halt_at, cyc, idx, eidx, fwait, ewait, retired, hold_until, exp_t;
    logic ack_v, done_v, req_now, ex_act, halt_seen;
    logic [5:0] opc;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, XW);

    // Step with 5-cycle execute, ignored STEP, RUN rise during step, RUN drop, reset in EXEC, halt.
    tbl.push_back(mk(5'b10000, XW, 3'd0, 6'b000000, 16'd0, 16'd0, 32'h0));
    tbl.push_back(mk(5'b00000, XW, 3'd0, 6'b000000, 16'd0, 16'd0, 32'h0));
    tbl.push_back(mk(5'b00100, XW, 3'd1, 6'b100000, 16'd0, 16'd0, 32'h0));
    tbl.push_back(mk(5'b00010, W1, 3'd2, 6'b000000, 16'd0, 16'd0, W1));
    tbl.push_back(mk(5'b00000, XW, 3'd3, 6'b010000, 16'd0, 16'd0, W1));
    tbl.push_back(mk(5'b00000, XW, 3'd3, 6'b000000, 16'd0, 16'd0, W1));
    tbl.push_back(mk(5'b00100, XW, 3'd3, 6'b000000, 16'd0, 16'd0, W1));
    tbl.push_back(mk(5'b00000, XW, 3'd3, 6'b000000, 16'd0, 16'd0, W1));
    tbl.push_back(mk(5'b00000, XW, 3'd3, 6'b000000, 16'd0, 16'd0, W1));
    tbl.push_back(mk(5'b00000, XW, 3'd3, 6'b000000, 16'd0, 16'd0, W1));
    tbl.push_back(mk(5'b00001, XW, 3'd4, 6'b001100, 16'd1, 16'd0, W1));
    tbl.push_back(mk(5'b00000, XW, 3'd0, 6'b000000, 16'd1, 16'd1, W1));
    tbl.push_back(mk(5'b00000, XW, 3'd0, 6'b000000, 16'd1, 16'd1, W1));
    tbl.push_back(mk(5'b00100, XW, 3'd1, 6'b100000, 16'd1, 16'd1, W1));
    tbl.push_back(mk(5'b01010, W2, 3'd2, 6'b000000, 16'd1, 16'd1, W2));
    tbl.push_back(mk(5'b01000, XW, 3'd3, 6'b010000, 16'd1, 16'd1, W2));
    tbl.push_back(mk(5'b01001, XW, 3'd4, 6'b001100, 16'd2, 16'd1, W2));
    tbl.push_back(mk(5'b01000, XW, 3'd0, 6'b000000, 16'd2, 16'd2, W2));
    tbl.push_back(mk(5'b01000, XW, 3'd1, 6'b100000, 16'd2, 16'd2, W2));
    tbl.push_back(mk(5'b00010, W3, 3'd2, 6'b000000, 16'd2, 16'd2, W3));
    tbl.push_back(mk(5'b00000, XW, 3'd3, 6'b010000, 16'd2, 16'd2, W3));
    tbl.push_back(mk(5'b00001, XW, 3'd4, 6'b001100, 16'd3, 16'd2, W3));
    tbl.push_back(mk(5'b00000, XW, 3'd0, 6'b000000, 16'd3, 16'd3, W3));
    tbl.push_back(mk(5'b00011, WH, 3'd0, 6'b000000, 16'd3, 16'd3, W3));
    tbl.push_back(mk(5'b01000, XW, 3'd1, 6'b100000, 16'd3, 16'd3, W3));
    tbl.push_back(mk(5'b01010, W1, 3'd2, 6'b000000, 16'd3, 16'd3, W1));
    tbl.push_back(mk(5'b01000, XW, 3'd3, 6'b010000, 16'd3, 16'd3, W1));
    tbl.push_back(mk(5'b11001, XW, 3'd0, 6'b000000, 16'd0, 16'd0, 32'h0));
    tbl.push_back(mk(5'b00000, XW, 3'd0, 6'b000000, 16'd0, 16'd0, 32'h0));
    tbl.push_back(mk(5'b01000, XW, 3'd1, 6'b100000, 16'd0, 16'd0, 32'h0));
    tbl.push_back(mk(5'b01010, W4, 3'd2, 6'b000000, 16'd0, 16'd0, W4));
    tbl.push_back(mk(5'b01000, XW, 3'd3, 6'b010000, 16'd0, 16'd0, W4));
    tbl.push_back(mk(5'b01001, XW, 3'd4, 6'b001100, 16'd1, 16'd0, W4));
    tbl.push_back(mk(5'b01000, XW, 3'd1, 6'b100000, 16'd1, 16'd1, W4));
    tbl.push_back(mk(5'b01010, WH, 3'd2, 6'b000000, 16'd1, 16'd1, WH));
    tbl.push_back(mk(5'b01000, XW, 3'd5, 6'b000001, 16'd1, 16'd1, WH));
    tbl.push_back(mk(5'b00100, XW, 3'd5, 6'b000001, 16'd1, 16'd1, WH));
    tbl.push_back(mk(5'b01100, XW, 3'd5, 6'b000001, 16'd1, 16'd1, WH));
    tbl.push_back(mk(5'b01011, W1, 3'd5, 6'b000001, 16'd1, 16'd1, WH));

    foreach (tbl[i]) begin
      drive(tbl[i].ins[4], tbl[i].ins[3], tbl[i].ins[2], tbl[i].ins[1], tbl[i].ins[0], tbl[i].rdata);
      tick();
      chk($sformatf("row%0d STATE", i), 32'(STATE), 32'(tbl[i].st));
      chk($sformatf("row%0d IMEM_REQ", i), 32'(IMEM_REQ), 32'(tbl[i].outs[5]));
      chk($sformatf("row%0d EX_START", i), 32'(EX_START), 32'(tbl[i].outs[4]));
      chk($sformatf("row%0d RF_WE", i), 32'(RF_WE), 32'(tbl[i].outs[3]));
      chk($sformatf("row%0d PC_EN", i), 32'(PC_EN), 32'(tbl[i].outs[2]));
      chk($sformatf("row%0d FETCH_ERR", i), 32'(FETCH_ERR), 32'(tbl[i].outs[1]));
      chk($sformatf("row%0d HALTED", i), 32'(HALTED), 32'(tbl[i].outs[0]));
      chk($sformatf("row%0d INSTR_CNT", i), 32'(INSTR_CNT), 32'(tbl[i].cnt));
      chk($sformatf("row%0d IMEM_ADDR", i), 32'(IMEM_ADDR), 32'(tbl[i].addr));
      chk($sformatf("row%0d IR", i), IR, tbl[i].ir);
    end

    // Fetch timeout: exactly TO request cycles, then sticky error parks the FSM in IDLE.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, XW);
    n_req = 0;
    pce_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (PC_EN) pce_cnt++;
      if (!IMEM_REQ) break;
      n_req++;
    end
    chk("timeout request cycles", 32'(n_req), 32'(TO));
    chk("timeout FETCH_ERR", 32'(FETCH_ERR), 32'd1);
    chk("timeout STATE", 32'(STATE), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (PC_EN || IMEM_REQ) pce_cnt++;
    end
    chk("timeout stays idle", 32'(STATE), 32'd0);
    chk("timeout no PC_EN or request", 32'(pce_cnt), 32'd0);

    // ACK on the final watchdog cycle must still complete the fetch.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, XW);
    tick();
    for (int k = 1; k < TO; k++) tick();
    chk("ack at TO still fetching", 32'(IMEM_REQ), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, W2);
    tick();
    chk("ack at TO STATE", 32'(STATE), 32'd2);
    chk("ack at TO FETCH_ERR", 32'(FETCH_ERR), 32'd0);
    chk("ack at TO IR", IR, W2);

    // Counter wrap: preload near the top, then retire two instructions.
    do_reset();
    force dut.instr_cnt = 16'hFFFE;
    tick();
    release dut.instr_cnt;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, W1);
    pce_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (PC_EN) pce_cnt++;
      if (k == 4) begin
        chk("wrap PC_EN first", 32'(PC_EN), 32'd1);
        chk("wrap INSTR_CNT FFFF", 32'(INSTR_CNT), 32'h0000_FFFF);
      end
      if (k == 8) begin
        chk("wrap PC_EN second", 32'(PC_EN), 32'd1);
        chk("wrap INSTR_CNT 0", 32'(INSTR_CNT), 32'h0);
      end
    end
    chk("wrap PC_EN count", 32'(pce_cnt), 32'd2);

    // Randomized run: each instruction costs (ack wait + 1) + 1 + (ex wait + 1) + 1 cycles.
    for (int i = 0; i < N; i++) begin
      opc = 6'($urandom_range(0, 62));
      da[i] = (i < 3) ? 0 : int'($urandom_range(0, TO - 1));
      de[i] = (i < 3) ? 0 : int'($urandom_range(0, 6));
      words[i] = {opc, 26'($urandom())};
    end
    words[N-1][31:26] = 6'h3F;
    t = 0;
    for (int i = 0; i < N - 1; i++) begin
      t += da[i] + de[i] + 4;
      exp_wb.push_back(t);
    end
    halt_at = t + da[N-1] + 3;

    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, XW);
    cyc = 0; idx = 0; eidx = 0; fwait = 0; ewait = 0; retired = 0; hold_until = 0;
    ex_act = 1'b0; halt_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      req_now = IMEM_REQ;
      ack_v = req_now && (idx < N) && (fwait == da[idx]);
      if (EX_START) begin
        ex_act = 1'b1;
        ewait = 0;
        if (eidx < N) chk("rand IR at EX_START", IR, words[eidx]);
      end
      done_v = ex_act && (eidx < N) && (ewait == de[eidx]);
      drive(1'b0, 1'b1, 1'b0, ack_v, done_v, (idx < N) ? words[idx] : XW);
      tick();
      cyc++;
      if (ack_v) begin
        idx++;
        fwait = 0;
      end else if (req_now) begin
        fwait++;
      end
      if (done_v) begin
        ex_act = 1'b0;
        eidx++;
      end else if (ex_act) begin
        ewait++;
      end
      if (PC_EN) begin
        exp_t = (exp_wb.size() > 0) ? exp_wb.pop_front() : -1;
        chk("rand PC_EN cycle", 32'(cyc), 32'(exp_t));
        chk("rand RF_WE with PC_EN", 32'(RF_WE), 32'd1);
        chk("rand INSTR_CNT at WB", 32'(INSTR_CNT), 32'(retired + 1));
        chk("rand IMEM_ADDR at WB", 32'(IMEM_ADDR), 32'(retired));
        retired++;
      end
      if (HALTED && !halt_seen) begin
        halt_seen = 1'b1;
        hold_until = cyc + 5;
        chk("rand halt cycle", 32'(cyc), 32'(halt_at));
        chk("rand halt STATE", 32'(STATE), 32'd5);
      end
      if (halt_seen && (cyc >= hold_until)) break;
    end
    chk("rand halted reached", 32'(halt_seen), 32'd1);
    chk("rand retired count", 32'(retired), 32'(N - 1));
    chk("rand pending write-backs", 32'(exp_wb.size()), 32'd0);
    chk("rand final INSTR_CNT", 32'(INSTR_CNT), 32'(N - 1));
    chk("rand final IMEM_ADDR", 32'(IMEM_ADDR), 32'(N - 1));
    chk("rand final STATE", 32'(STATE), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
